// File: rtl/wja_bus_lite_n_if.sv
// AXI4-Lite channel bundle shared by the wja_bus_lite_n register bank and its bus master.
interface wja_bus_lite_n_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/wja_bus_lite_n.sv
// AXI4-Lite slave register bank: N_OREG read/write control registers, N_IREG read-only
// status registers, byte-strobe writes, SLVERR on illegal access, per-register access strobes.
module wja_bus_lite_n #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 8,
  parameter int              N_OREG    = 4,
  parameter int              N_IREG    = 4,
  parameter logic [DATA_W-1:0] OREG_INIT = {DATA_W{1'b0}}
) (
  input  logic                                      s00_axi_aclk,
  input  logic                                      s00_axi_areset,
  wja_bus_lite_n_if.slave                           s00_axi,
  output logic [N_OREG*DATA_W-1:0]                  oreg,
  input  logic [((N_IREG > 0) ? N_IREG : 1)*DATA_W-1:0] ireg,
  output logic [N_OREG-1:0]                         owr_pulse,
  output logic [((N_IREG > 0) ? N_IREG : 1)-1:0]    ird_pulse
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_W - ADDR_LSB;
  localparam int N_IRP    = (N_IREG > 0) ? N_IREG : 1;

  logic                rdy_en_r;
  logic                aw_held_r;
  logic                w_held_r;
  logic [IDX_W-1:0]    aw_idx_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [STRB_W-1:0]   wstrb_r;
  logic                bvalid_r;
  logic [1:0]          bresp_r;
  logic                rvalid_r;
  logic [DATA_W-1:0]   rdata_r;
  logic [1:0]          rresp_r;
  logic [DATA_W-1:0]   oreg_r [N_OREG];
  logic [N_OREG-1:0]   owr_pulse_r;
  logic [N_IRP-1:0]    ird_pulse_r;

  logic                awready_s;
  logic                wready_s;
  logic                arready_s;
  logic                aw_hs_s;
  logic                w_hs_s;
  logic                ar_hs_s;
  logic                commit_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [STRB_W-1:0]   wr_strb_s;
  logic [N_OREG-1:0]   wr_osel_s;
  logic                wr_ok_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [N_OREG-1:0]   rd_osel_s;
  logic [N_IRP-1:0]    rd_isel_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                rd_err_s;
  logic                unused_s;

  // rdy_en_r keeps every ready low until the first edge after reset release.
  assign awready_s = rdy_en_r & ~aw_held_r & ~bvalid_r;
  assign wready_s  = rdy_en_r & ~w_held_r & ~bvalid_r;
  assign arready_s = rdy_en_r & ~rvalid_r;
  assign aw_hs_s   = s00_axi.awvalid & awready_s;
  assign w_hs_s    = s00_axi.wvalid & wready_s;
  assign ar_hs_s   = s00_axi.arvalid & arready_s;
  assign commit_s  = (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);

  assign wr_idx_s  = aw_held_r ? aw_idx_r : s00_axi.awaddr[ADDR_W-1:ADDR_LSB];
  assign wr_data_s = w_held_r ? wdata_r : s00_axi.wdata;
  assign wr_strb_s = w_held_r ? wstrb_r : s00_axi.wstrb;
  assign rd_idx_s  = s00_axi.araddr[ADDR_W-1:ADDR_LSB];

  assign unused_s = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[ADDR_LSB-1:0], s00_axi.araddr[ADDR_LSB-1:0]};

  // Write target decode: one-hot oreg select, anything else answers SLVERR.
  always_comb begin
    wr_osel_s = {N_OREG{1'b0}};
    for (int i = 0; i < N_OREG; i++) begin
      wr_osel_s[i] = (wr_idx_s == IDX_W'(i));
    end
    wr_ok_s = |wr_osel_s;
  end

  // Read target decode and AND-OR data mux; unmapped reads yield zero data.
  always_comb begin
    rd_osel_s = {N_OREG{1'b0}};
    rd_isel_s = {N_IRP{1'b0}};
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < N_OREG; i++) begin
      rd_osel_s[i] = (rd_idx_s == IDX_W'(i));
      rd_data_s    = rd_data_s | (oreg_r[i] & {DATA_W{rd_osel_s[i]}});
    end
    for (int j = 0; j < N_IREG; j++) begin
      rd_isel_s[j] = (rd_idx_s == IDX_W'(N_OREG + j));
      rd_data_s    = rd_data_s | (ireg[j*DATA_W +: DATA_W] & {DATA_W{rd_isel_s[j]}});
    end
    rd_err_s = ~((|rd_osel_s) | (|rd_isel_s));
  end

  // Write channel: hold AW/W independently until paired, then commit and respond.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rdy_en_r  <= 1'b0;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      aw_idx_r  <= {IDX_W{1'b0}};
      wdata_r   <= {DATA_W{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
    end else begin
      rdy_en_r <= 1'b1;
      if (commit_s) begin
        aw_held_r <= 1'b0;
        w_held_r  <= 1'b0;
        bvalid_r  <= 1'b1;
        bresp_r   <= wr_ok_s ? 2'b00 : 2'b10;
      end else begin
        if (aw_hs_s) begin
          aw_held_r <= 1'b1;
          aw_idx_r  <= s00_axi.awaddr[ADDR_W-1:ADDR_LSB];
        end
        if (w_hs_s) begin
          w_held_r <= 1'b1;
          wdata_r  <= s00_axi.wdata;
          wstrb_r  <= s00_axi.wstrb;
        end
        if (bvalid_r && s00_axi.bready) begin
          bvalid_r <= 1'b0;
        end
      end
    end
  end

  // Output register file with byte-lane enables and per-register write strobe.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < N_OREG; i++) begin
        oreg_r[i] <= OREG_INIT;
      end
      owr_pulse_r <= {N_OREG{1'b0}};
    end else begin
      for (int i = 0; i < N_OREG; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (commit_s && wr_osel_s[i] && wr_strb_s[b]) begin
            oreg_r[i][b*8 +: 8] <= wr_data_s[b*8 +: 8];
          end
        end
      end
      owr_pulse_r <= {N_OREG{commit_s}} & wr_osel_s;
    end
  end

  // Read channel: capture data/response at AR handshake and hold until R handshake.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      rvalid_r    <= 1'b0;
      rdata_r     <= {DATA_W{1'b0}};
      rresp_r     <= 2'b00;
      ird_pulse_r <= {N_IRP{1'b0}};
    end else begin
      ird_pulse_r <= {N_IRP{ar_hs_s}} & rd_isel_s;
      if (ar_hs_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_err_s ? 2'b10 : 2'b00;
      end else if (rvalid_r && s00_axi.rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  assign s00_axi.awready = awready_s;
  assign s00_axi.wready  = wready_s;
  assign s00_axi.bvalid  = bvalid_r;
  assign s00_axi.bresp   = bresp_r;
  assign s00_axi.arready = arready_s;
  assign s00_axi.rvalid  = rvalid_r;
  assign s00_axi.rdata   = rdata_r;
  assign s00_axi.rresp   = rresp_r;
  assign owr_pulse       = owr_pulse_r;
  assign ird_pulse       = ird_pulse_r;

  for (genvar g = 0; g < N_OREG; g++) begin : g_oreg
    assign oreg[g*DATA_W +: DATA_W] = oreg_r[g];
  end

endmodule
